hazard_unit_param: RTL and testbench



---
 rtl/hazard_unit_param_if.sv | 58 +++++
 rtl/hazard_unit_param.sv | 110 +++++++++++
 tb/tb_hazard_unit_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_param_if.sv
// Hazard unit bundle: Decode/Execute source reads, stage destinations and
// control flags in; forwarding selects, stage enables/clears and
// performance counters out.
interface hazard_unit_param_if #(
  parameter int NREG  = 16,
  parameter int NSRC  = 3,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(NREG);

  logic [NSRC*AW-1:0] RAD;
  logic [NSRC-1:0]    RAValidD;
  logic [NSRC*AW-1:0] RAE;
  logic [NSRC-1:0]    RAValidE;
  logic [AW-1:0]      WA3E;
  logic [AW-1:0]      WA3M;
  logic [AW-1:0]      WA3W;
  logic               RegWriteE;
  logic               RegWriteM;
  logic               RegWriteW;
  logic               MemToRegE;
  logic               MulStartE;
  logic               PCSrcD;
  logic               PCSrcE;
  logic               PCSrcM;
  logic               PCSrcW;
  logic               BranchTakenE;
  logic               PerfClr;

  logic [2*NSRC-1:0]  ForwardE;
  logic               StallF;
  logic               StallD;
  logic               StallE;
  logic               FlushD;
  logic               FlushE;
  logic               BubbleM;
  logic               MulBusy;
  logic [CNT_W-1:0]   StallCnt;
  logic [CNT_W-1:0]   FlushCnt;

  // Hazard unit side
  modport slave (
    input  RAD, RAValidD, RAE, RAValidE, WA3E, WA3M, WA3W,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MulStartE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, PerfClr,
    output ForwardE, StallF, StallD, StallE, FlushD, FlushE, BubbleM,
           MulBusy, StallCnt, FlushCnt
  );

  // Controller/datapath side
  modport master (
    output RAD, RAValidD, RAE, RAValidE, WA3E, WA3M, WA3W,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MulStartE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, PerfClr,
    input  ForwardE, StallF, StallD, StallE, FlushD, FlushE, BubbleM,
           MulBusy, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_unit_param.sv
// Parametrised hazard unit for the F/D/E/M/W ARM pipeline: per-port
// forwarding, load-use and control stalls/flushes, a multi-cycle Execute
// hold and saturating stall/flush performance counters.
module hazard_unit_param #(
  parameter int NREG    = 16,
  parameter int NSRC    = 3,
  parameter int PC_REG  = 15,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_param_if.slave hz
);
  localparam int              AW       = $clog2(NREG);
  localparam int              CW       = $clog2(MUL_LAT) + 1;
  localparam logic [AW-1:0]   PC_IDX   = AW'(PC_REG);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] PERF_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

  logic [2*NSRC-1:0] w_fwd;
  logic              w_ld_stall;
  logic              w_pc_pend;
  logic              w_mul_hold;
  logic              w_stall_d;
  logic              w_flush_d;
  logic              w_flush_e;
  logic [CW-1:0]     r_cnt;
  logic              r_mul_busy;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  // Per-port forwarding select; the younger M result beats W, PC never forwards
  always_comb begin
    logic [AW-1:0] ra;
    w_fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      ra = hz.RAE[i*AW +: AW];
      if (hz.RAValidE[i] && hz.RegWriteM && (ra == hz.WA3M) && (ra != PC_IDX)) begin
        w_fwd[2*i +: 2] = 2'b10;
      end else if (hz.RAValidE[i] && hz.RegWriteW && (ra == hz.WA3W) && (ra != PC_IDX)) begin
        w_fwd[2*i +: 2] = 2'b01;
      end else begin
        w_fwd[2*i +: 2] = 2'b00;
      end
    end
  end

  // Load-use detection: a load in E feeding any valid Decode source
  always_comb begin
    w_ld_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz.RAValidD[i] && (hz.RAD[i*AW +: AW] == hz.WA3E)) begin
        w_ld_stall = w_ld_stall | (hz.MemToRegE & hz.RegWriteE);
      end else begin
        w_ld_stall = w_ld_stall;
      end
    end
  end

  // Multi-cycle hold is gated by reset so an aborted op drops its stall at once
  assign w_mul_hold = reset & hz.MulStartE & (r_cnt < CNT_LAST);
  assign w_pc_pend  = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
  assign w_stall_d  = w_ld_stall | w_mul_hold;
  assign w_flush_d  = w_pc_pend | hz.PCSrcW | hz.BranchTakenE;
  // A held Execute stage is never flushed, even by a taken branch
  assign w_flush_e  = (w_ld_stall | hz.BranchTakenE) & ~w_mul_hold;

  assign hz.ForwardE = w_fwd;
  assign hz.StallE   = w_mul_hold;
  assign hz.BubbleM  = w_mul_hold;
  assign hz.StallD   = w_stall_d;
  assign hz.StallF   = w_ld_stall | w_pc_pend | w_mul_hold;
  assign hz.FlushD   = w_flush_d;
  assign hz.FlushE   = w_flush_e;
  assign hz.MulBusy  = r_mul_busy;
  assign hz.StallCnt = r_stall_cnt;
  assign hz.FlushCnt = r_flush_cnt;

  // Execute occupancy count: advances while holding, returns to 0 as the op leaves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_mul_busy <= 1'b0;
    end else begin
      r_cnt      <= w_mul_hold ? (r_cnt + CNT_ONE) : '0;
      r_mul_busy <= w_mul_hold;
    end
  end

  // Saturating performance counters; a clear overrides a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (hz.PerfClr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_d && (r_stall_cnt != PERF_MAX)) begin
        r_stall_cnt <= r_stall_cnt + PERF_ONE;
      end
      if ((w_flush_d || w_flush_e) && (r_flush_cnt != PERF_MAX)) begin
        r_flush_cnt <= r_flush_cnt + PERF_ONE;
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit_param.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a behavioural model for two configurations (MUL_LAT=3/CNT_W=16
// and MUL_LAT=1/CNT_W=4) driven with identical inputs.
module tb_hazard_unit_param;
  logic clk = 1'b0;
  logic reset_n;

  hazard_unit_param_if #(.NREG(16), .NSRC(3), .CNT_W(16)) if_a ();
  hazard_unit_param_if #(.NREG(16), .NSRC(3), .CNT_W(4))  if_b ();

  hazard_unit_param #(.NREG(16), .NSRC(3), .PC_REG(15), .MUL_LAT(3), .CNT_W(16))
    dut_a (.clk(clk), .reset(reset_n), .hz(if_a.slave));
  hazard_unit_param #(.NREG(16), .NSRC(3), .PC_REG(15), .MUL_LAT(1), .CNT_W(4))
    dut_b (.clk(clk), .reset(reset_n), .hz(if_b.slave));

  assign if_b.RAD          = if_a.RAD;
  assign if_b.RAValidD     = if_a.RAValidD;
  assign if_b.RAE          = if_a.RAE;
  assign if_b.RAValidE     = if_a.RAValidE;
  assign if_b.WA3E         = if_a.WA3E;
  assign if_b.WA3M         = if_a.WA3M;
  assign if_b.WA3W         = if_a.WA3W;
  assign if_b.RegWriteE    = if_a.RegWriteE;
  assign if_b.RegWriteM    = if_a.RegWriteM;
  assign if_b.RegWriteW    = if_a.RegWriteW;
  assign if_b.MemToRegE    = if_a.MemToRegE;
  assign if_b.MulStartE    = if_a.MulStartE;
  assign if_b.PCSrcD       = if_a.PCSrcD;
  assign if_b.PCSrcE       = if_a.PCSrcE;
  assign if_b.PCSrcM       = if_a.PCSrcM;
  assign if_b.PCSrcW       = if_a.PCSrcW;
  assign if_b.BranchTakenE = if_a.BranchTakenE;
  assign if_b.PerfClr      = if_a.PerfClr;

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state per configuration
  int     m_lat  [2] = '{3, 1};
  longint m_max  [2] = '{65535, 15};
  int     m_age  [2];
  longint m_sc   [2];
  longint m_fc   [2];
  bit     m_hold [2];
  bit     m_stl  [2];
  bit     m_fl   [2];

  // A taken branch must never coincide with a multi-cycle op in E
  always @(negedge clk) begin
    assert (!(if_a.BranchTakenE && if_a.MulStartE))
      else $error("FAIL illegal_branch_mul: both asserted");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic clear_inputs();
    if_a.RAD = '0; if_a.RAValidD = '0; if_a.RAE = '0; if_a.RAValidE = '0;
    if_a.WA3E = '0; if_a.WA3M = '0; if_a.WA3W = '0;
    if_a.RegWriteE = 1'b0; if_a.RegWriteM = 1'b0; if_a.RegWriteW = 1'b0;
    if_a.MemToRegE = 1'b0; if_a.MulStartE = 1'b0;
    if_a.PCSrcD = 1'b0; if_a.PCSrcE = 1'b0; if_a.PCSrcM = 1'b0; if_a.PCSrcW = 1'b0;
    if_a.BranchTakenE = 1'b0; if_a.PerfClr = 1'b0;
  endtask

  // Settle, then compare every output of both configurations with the model
  task automatic settle_check();
    logic [5:0] fe;
    bit ld, pend;
    int src, prov;
    #2;
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin m_age[d] = 0; m_sc[d] = 0; m_fc[d] = 0; end
    end
    // Forwarding: newest producer of the register wins; PC (15) is never forwarded
    fe = '0;
    for (int i = 0; i < 3; i++) begin
      src  = int'(if_a.RAE[i*4 +: 4]);
      prov = 0;
      if (if_a.RAValidE[i] && src != 15) begin
        if (if_a.RegWriteW && src == int'(if_a.WA3W)) prov = 1;
        if (if_a.RegWriteM && src == int'(if_a.WA3M)) prov = 2;
      end
      fe[2*i +: 2] = 2'(prov);
    end
    ld = 1'b0;
    if (if_a.MemToRegE && if_a.RegWriteE)
      for (int i = 0; i < 3; i++)
        if (if_a.RAValidD[i] && if_a.RAD[i*4 +: 4] == if_a.WA3E) ld = 1'b1;
    pend = if_a.PCSrcD || if_a.PCSrcE || if_a.PCSrcM;
    for (int d = 0; d < 2; d++) begin
      string p;
      bit fd, fle;
      p = (d == 0) ? "a_" : "b_";
      // The op needs m_lat cycles in E; it holds while more cycles remain
      m_hold[d] = reset_n && if_a.MulStartE && (m_age[d] + 1 < m_lat[d]);
      m_stl[d]  = ld || m_hold[d];
      fd  = pend || if_a.PCSrcW || if_a.BranchTakenE;
      fle = (ld || if_a.BranchTakenE) && !m_hold[d];
      m_fl[d]   = fd || fle;
      chk({p, "fwd"},    (d == 0) ? if_a.ForwardE : if_b.ForwardE, fe);
      chk({p, "stallf"}, (d == 0) ? if_a.StallF : if_b.StallF, ld || pend || m_hold[d]);
      chk({p, "stalld"}, (d == 0) ? if_a.StallD : if_b.StallD, m_stl[d]);
      chk({p, "stalle"}, (d == 0) ? if_a.StallE : if_b.StallE, m_hold[d]);
      chk({p, "bubblem"},(d == 0) ? if_a.BubbleM : if_b.BubbleM, m_hold[d]);
      chk({p, "flushd"}, (d == 0) ? if_a.FlushD : if_b.FlushD, fd);
      chk({p, "flushe"}, (d == 0) ? if_a.FlushE : if_b.FlushE, fle);
      chk({p, "mulbusy"},(d == 0) ? if_a.MulBusy : if_b.MulBusy, m_age[d] != 0);
      chk({p, "stallcnt"}, (d == 0) ? longint'(if_a.StallCnt) : longint'(if_b.StallCnt), m_sc[d]);
      chk({p, "flushcnt"}, (d == 0) ? longint'(if_a.FlushCnt) : longint'(if_b.FlushCnt), m_fc[d]);
    end
  endtask

  // Advance the model across the rising edge, then move past it
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (reset_n) begin
        m_age[d] = m_hold[d] ? m_age[d] + 1 : 0;
        if (if_a.PerfClr) begin
          m_sc[d] = 0; m_fc[d] = 0;
        end else begin
          if (m_stl[d] && m_sc[d] < m_max[d]) m_sc[d]++;
          if (m_fl[d]  && m_fc[d] < m_max[d]) m_fc[d]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    if_a.MemToRegE = 1'b1; if_a.RegWriteE = 1'b1; if_a.WA3E = 4'd5;
    if_a.RAD = 12'h050; if_a.RAValidD = 3'b010;
  endtask

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    bit exp_se [4];
    bit exp_bz [4];
    bit mul_on;
    exp_se = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_bz = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int d = 0; d < 2; d++) begin m_age[d] = 0; m_sc[d] = 0; m_fc[d] = 0; end

    // Reset with all-zero inputs
    reset_n = 1'b0;
    clear_inputs();
    settle_check();
    tick();
    reset_n = 1'b1;
    settle_check();
    tick();

    // Forwarding priority M over W, PC excluded
    if_a.WA3M = 4'd3; if_a.WA3W = 4'd3; if_a.RegWriteM = 1'b1; if_a.RegWriteW = 1'b1;
    if_a.RAE = 12'h003; if_a.RAValidE = 3'b001;
    settle_check(); chk("dir_fwd_m", if_a.ForwardE[1:0], 2'b10); tick();
    if_a.RegWriteM = 1'b0;
    settle_check(); chk("dir_fwd_w", if_a.ForwardE[1:0], 2'b01); tick();
    if_a.RegWriteM = 1'b1; if_a.WA3M = 4'd15; if_a.WA3W = 4'd15; if_a.RAE = 12'h00f;
    settle_check(); chk("dir_fwd_pc", if_a.ForwardE[1:0], 2'b00); tick();

    // Load-use: one stall cycle, then the load is forwarded from W
    clear_inputs(); if_a.PerfClr = 1'b1;
    settle_check(); tick();
    clear_inputs(); set_load_use();
    settle_check();
    chk("dir_ld_stallf", if_a.StallF, 1'b1);
    chk("dir_ld_stalld", if_a.StallD, 1'b1);
    chk("dir_ld_flushe", if_a.FlushE, 1'b1);
    tick();
    if_a.MemToRegE = 1'b0; if_a.RegWriteE = 1'b0; if_a.WA3M = 4'd5; if_a.RegWriteM = 1'b1;
    settle_check();
    chk("dir_ld_release", if_a.StallD, 1'b0);
    chk("dir_ld_cnt", longint'(if_a.StallCnt), 1);
    tick();
    clear_inputs(); if_a.WA3W = 4'd5; if_a.RegWriteW = 1'b1;
    if_a.RAE = 12'h050; if_a.RAValidE = 3'b010;
    settle_check(); chk("dir_ld_fwd_w", if_a.ForwardE[3:2], 2'b01); tick();

    // Multi-cycle op held in E, then a back-to-back op restarts
    clear_inputs(); if_a.MulStartE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle_check();
      chk("dir_mul_stalle", if_a.StallE, exp_se[k]);
      chk("dir_mul_busy", if_a.MulBusy, exp_bz[k]);
      chk("dir_mul_flushe", if_a.FlushE, 1'b0);
      chk("dir_mul1_stalle", if_b.StallE, 1'b0);
      tick();
    end
    clear_inputs();
    settle_check(); tick();
    settle_check(); tick();

    // Branch and pending PC writes
    if_a.BranchTakenE = 1'b1;
    settle_check();
    chk("dir_br_flushd", if_a.FlushD, 1'b1);
    chk("dir_br_flushe", if_a.FlushE, 1'b1);
    chk("dir_br_stallf", if_a.StallF, 1'b0);
    tick();
    clear_inputs(); if_a.PCSrcD = 1'b1;
    settle_check(); chk("dir_pcd_stallf", if_a.StallF, 1'b1); chk("dir_pcd_flushd", if_a.FlushD, 1'b1); tick();
    clear_inputs(); if_a.PCSrcM = 1'b1;
    settle_check(); chk("dir_pcm_stallf", if_a.StallF, 1'b1); tick();
    clear_inputs(); if_a.PCSrcW = 1'b1;
    settle_check(); chk("dir_pcw_stallf", if_a.StallF, 1'b0); chk("dir_pcw_flushd", if_a.FlushD, 1'b1); tick();

    // Reset in the middle of a hold
    clear_inputs(); if_a.MulStartE = 1'b1;
    settle_check(); tick();
    reset_n = 1'b0;
    settle_check();
    chk("dir_rst_stalle", if_a.StallE, 1'b0);
    chk("dir_rst_busy", if_a.MulBusy, 1'b0);
    chk("dir_rst_stallcnt", longint'(if_a.StallCnt), 0);
    chk("dir_rst_flushcnt", longint'(if_a.FlushCnt), 0);
    tick();
    reset_n = 1'b1;
    settle_check(); chk("dir_rst_hold0", if_a.StallE, 1'b1); tick();
    settle_check(); chk("dir_rst_hold1", if_a.StallE, 1'b1); tick();
    settle_check(); chk("dir_rst_hold2", if_a.StallE, 1'b0); tick();

    // Saturation of the 4-bit counter, then a clear against an increment
    clear_inputs(); set_load_use();
    for (int k = 0; k < 20; k++) begin settle_check(); tick(); end
    settle_check(); chk("dir_sat_b", longint'(if_b.StallCnt), 15);
    tick();
    if_a.PerfClr = 1'b1;
    settle_check(); tick();
    if_a.PerfClr = 1'b0;
    settle_check();
    chk("dir_clr_b", longint'(if_b.StallCnt), 0);
    chk("dir_clr_a", longint'(if_a.StallCnt), 0);
    tick();

    // Randomized traffic with a sticky multi-cycle op and rare resets
    mul_on = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 3; i++) begin
        if_a.RAD[i*4 +: 4] = rnd_reg();
        if_a.RAE[i*4 +: 4] = rnd_reg();
      end
      if_a.RAValidD = 3'($urandom);
      if_a.RAValidE = 3'($urandom);
      if_a.WA3E = rnd_reg(); if_a.WA3M = rnd_reg(); if_a.WA3W = rnd_reg();
      if_a.RegWriteE = 1'($urandom); if_a.RegWriteM = 1'($urandom); if_a.RegWriteW = 1'($urandom);
      if_a.MemToRegE = ($urandom_range(0, 3) == 0);
      mul_on = mul_on ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
      if_a.MulStartE = mul_on;
      if_a.BranchTakenE = !mul_on && ($urandom_range(0, 7) == 0);
      if_a.PCSrcD = ($urandom_range(0, 7) == 0);
      if_a.PCSrcE = ($urandom_range(0, 7) == 0);
      if_a.PCSrcM = ($urandom_range(0, 7) == 0);
      if_a.PCSrcW = ($urandom_range(0, 7) == 0);
      if_a.PerfClr = ($urandom_range(0, 63) == 0);
      settle_check();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
